dram_axi_mem_slave: RTL and testbench

- Synthesizable single-port-per-direction AXI memory slave that emulates DRAM behind `dram_axi_dma_stream`, directly downstream of its `m_axi_*` read and write channels.
- Serves single-beat reads with programmable latency and accepts single-beat writes whose AW and W halves arrive in any order.
- Used in simulation and FPGA bring-up in place of the external memory controller, so RDMA/WDMA traffic can be checked end to end.

---
 rtl/dram_axi_mem_slave.sv | 201 ++++++++++++++++++++
 tb/tb_dram_axi_mem_slave.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_axi_mem_slave.sv
// AXI-style single-beat memory slave standing in for external DRAM.
// Ports: clk, reset (async, active-high); AR/R read channel (s_axi_ar*, s_axi_r*);
// AW/W write channel (s_axi_aw*, s_axi_w*, no B); rd_count / wr_count
// count completed R handshakes and committed writes (16-bit, wrapping).
module dram_axi_mem_slave #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 1024,
    parameter int RD_LATENCY   = 2,
    parameter int INIT_PATTERN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rstate_t;

    logic [DATA_W-1:0] mem [DEPTH];

    rstate_t           state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  ridx_q, ridx_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              arready_q, arready_d;

    logic              aw_held_q, aw_held_d;
    logic [IDX_W-1:0]  awidx_q, awidx_d;
    logic              w_held_q, w_held_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;

    logic [15:0]       rd_cnt_q, rd_cnt_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;

    logic              aw_hs, w_hs, commit;
    logic [IDX_W-1:0]  widx;
    logic [DATA_W-1:0] wdat;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_araddr[ADDR_W-1:IDX_W+2],
                                s_axi_araddr[1:0],
                                s_axi_awaddr[ADDR_W-1:IDX_W+2],
                                s_axi_awaddr[1:0]};

    // Read channel FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ridx_d    = ridx_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        rd_cnt_d  = rd_cnt_q;
        unique case (state_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    ridx_d  = s_axi_araddr[IDX_W+1:2];
                    cnt_d   = 4'(RD_LATENCY - 1);
                    state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (cnt_q == 4'd0) begin
                    // Sampled with the pre-edge array: a same-edge write
                    // commit to this index is not visible here.
                    rdata_d  = mem[ridx_q];
                    rvalid_d = 1'b1;
                    state_d  = R_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rvalid_d = 1'b0;
                    rd_cnt_d = rd_cnt_q + 16'd1;
                    state_d  = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
        arready_d = (state_d == R_IDLE);
    end

    // Write path: each half is either held or handshaking this cycle.
    always_comb begin
        aw_hs     = s_axi_awvalid && awready_q;
        w_hs      = s_axi_wvalid && wready_q;
        commit    = (aw_held_q || aw_hs) && (w_held_q || w_hs);
        widx      = aw_held_q ? awidx_q : s_axi_awaddr[IDX_W+1:2];
        wdat      = w_held_q ? wdata_q : s_axi_wdata;
        aw_held_d = aw_held_q;
        awidx_d   = awidx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wr_cnt_d  = wr_cnt_q;
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            wr_cnt_d  = wr_cnt_q + 16'd1;
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                awidx_d   = s_axi_awaddr[IDX_W+1:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = s_axi_wdata;
            end
        end
        awready_d = !aw_held_d;
        wready_d  = !w_held_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= R_IDLE;
            cnt_q     <= '0;
            ridx_q    <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            aw_held_q <= 1'b0;
            awidx_q   <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ridx_q    <= ridx_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            arready_q <= arready_d;
            aw_held_q <= aw_held_d;
            awidx_q   <= awidx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // Storage: preloaded with its own index under reset when enabled,
    // otherwise left untouched by reset.
    generate
        if (INIT_PATTERN == 1) begin : g_init
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[i] <= DATA_W'(i);
                    end
                end else if (commit) begin
                    mem[widx] <= wdat;
                end
            end
        end else begin : g_noinit
            always_ff @(posedge clk) begin
                if (commit) begin
                    mem[widx] <= wdat;
                end
            end
        end
    endgenerate

    assign s_axi_arready = arready_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign rd_count      = rd_cnt_q;
    assign wr_count      = wr_cnt_q;

endmodule

// File: tb/tb_dram_axi_mem_slave.sv
// Directed self-checking bench for dram_axi_mem_slave.
// Default parameters: DEPTH=1024, RD_LATENCY=2, INIT_PATTERN=1.
module tb_dram_axi_mem_slave;

    logic        clk;
    logic        reset;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int total;
    int passed;
    int fails;

    dram_axi_mem_slave dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .rd_count      (rd_count),
        .wr_count      (wr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data);
        int n;
        araddr  = addr;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("ar_timeout", 32'd1, 32'd0);
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("r_timeout", 32'd1, 32'd0);
        data   = rdata;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        awaddr  = addr;
        wdata   = data;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        total   = 0;
        passed  = 0;
        fails   = 0;
        reset   = 1'b1;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wvalid  = 1'b0;
        tick();
        tick();
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        reset = 1'b0;
        tick();

        // Read 0x10 with latency 2.
        araddr  = 32'h10;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check("lat_n_arready", 32'(arready), 32'd0);
        check("lat_n_rvalid", 32'(rvalid), 32'd0);
        tick();
        check("lat_n1_arready", 32'(arready), 32'd0);
        check("lat_n1_rvalid", 32'(rvalid), 32'd0);
        tick();
        check("lat_n2_rvalid", 32'(rvalid), 32'd1);
        check("lat_n2_rdata", rdata, 32'd4);

        // Backpressure with a second AR waiting.
        araddr  = 32'h20;
        arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rvalid", 32'(rvalid), 32'd1);
            check("bp_rdata", rdata, 32'd4);
            check("bp_arready", 32'(arready), 32'd0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("hs_rvalid", 32'(rvalid), 32'd0);
        check("hs_rd_count", 32'(rd_count), 32'd1);
        check("hs_arready", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        check("ar2_accepted", 32'(arready), 32'd0);
        tick();
        tick();
        check("ar2_rvalid", 32'(rvalid), 32'd1);
        check("ar2_rdata", rdata, 32'd8);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("ar2_rd_count", 32'(rd_count), 32'd2);

        // Write: AW and W together.
        do_write(32'h40, 32'hDEADBEEF);
        check("w1_awready", 32'(awready), 32'd1);
        check("w1_wready", 32'(wready), 32'd1);
        check("w1_wr_count", 32'(wr_count), 32'd1);

        // Write: AW three cycles before W.
        awaddr  = 32'h44;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("w2_hold_awready", 32'(awready), 32'd0);
            check("w2_hold_wready", 32'(wready), 32'd1);
            check("w2_hold_count", 32'(wr_count), 32'd1);
            tick();
        end
        wdata  = 32'hCAFEF00D;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("w2_awready", 32'(awready), 32'd1);
        check("w2_wr_count", 32'(wr_count), 32'd2);

        // Write: W two cycles before AW.
        wdata  = 32'h12345678;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("w3_hold_wready", 32'(wready), 32'd0);
        check("w3_hold_awready", 32'(awready), 32'd1);
        tick();
        check("w3_hold_count", 32'(wr_count), 32'd2);
        awaddr  = 32'h48;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("w3_wready", 32'(wready), 32'd1);
        check("w3_wr_count", 32'(wr_count), 32'd3);

        do_read(32'h40, rd);
        check("rb_idx16", rd, 32'hDEADBEEF);
        do_read(32'h44, rd);
        check("rb_idx17", rd, 32'hCAFEF00D);
        do_read(32'h48, rd);
        check("rb_idx18", rd, 32'h12345678);
        check("rb_rd_count", 32'(rd_count), 32'd5);

        // Aliasing modulo DEPTH words.
        do_write(32'h1008, 32'hA5A5A5A5);
        do_read(32'h8, rd);
        check("alias_rdata", rd, 32'hA5A5A5A5);
        do_read(32'hC, rd);
        check("alias_neighbour", rd, 32'd3);

        // Same-edge read sample and write commit to index 5.
        araddr  = 32'h14;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        awaddr  = 32'h14;
        wdata   = 32'h11111111;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("coll_rvalid", 32'(rvalid), 32'd1);
        check("coll_old", rdata, 32'd5);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        do_read(32'h14, rd);
        check("coll_new", rd, 32'h11111111);

        // Reset with a read in flight and an AW held.
        awaddr  = 32'h30;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("mr_aw_held", 32'(awready), 32'd0);
        araddr  = 32'h30;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("mr_async_rvalid", 32'(rvalid), 32'd0);
        check("mr_async_arready", 32'(arready), 32'd1);
        check("mr_async_awready", 32'(awready), 32'd1);
        check("mr_async_rd_count", 32'(rd_count), 32'd0);
        check("mr_async_wr_count", 32'(wr_count), 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_no_phantom", 32'(rvalid), 32'd0);
        end
        check("mr_rd_count", 32'(rd_count), 32'd0);
        check("mr_wr_count", 32'(wr_count), 32'd0);
        wdata  = 32'h77777777;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("mr_no_commit", 32'(wr_count), 32'd0);
        check("mr_w_held", 32'(wready), 32'd0);
        awaddr  = 32'h34;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        do_read(32'h30, rd);
        check("mr_mem_idx12", rd, 32'd12);
        do_read(32'h34, rd);
        check("mr_mem_idx13", rd, 32'h77777777);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
